mem_stage_sram_ctrl: RTL and testbench

//   Memory-stage data-memory controller: turns one 32-bit load/store from EX/MEM into two 16-bit accesses on the external SRAM.

---
 rtl/arm_pkg.sv | 14 +
 rtl/mem_stage_sram_ctrl_phase_timer.sv | 31 +++
 rtl/mem_stage_sram_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared types for the memory-stage SRAM controller: FSM state encoding and half-word select constants.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_stage_sram_ctrl_phase_timer.sv
// Per-phase wait counter for the SRAM controller: counts 0..WAIT_CYCLES inside a half-word phase,
// flagging the last cycle (done) and the cycle before it (pre_done, used to lift the write strobe).
module sram_phase_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done,
  output logic pre_done
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

  logic [3:0] count_r;

  // Cycle index within the current phase; held at zero while clear is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 4'd0;
    end else if (clear) begin
      count_r <= 4'd0;
    end else begin
      count_r <= count_r + 4'd1;
    end
  end

  assign done     = (count_r == LAST);
  assign pre_done = ((count_r + 4'd1) == LAST);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage data-memory controller: splits one 32-bit load/store into two 16-bit SRAM accesses.
// Optional address range checking (addr_err output) is enabled with the SRAM_ADDR_CHECK_EN macro.
module mem_stage_sram_ctrl
  import arm_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_ADDR_W = 18,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
`ifdef SRAM_ADDR_CHECK_EN
  output logic                   addr_err,
`endif
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  localparam int WI_W = SRAM_ADDR_W - 1;

  mem_state_t              state_r;
  logic                    op_wr_r;
  logic [WI_W-1:0]         word_r;
  logic [31:0]             wdata_r;
  logic [31:0]             read_data_r;
  logic [SRAM_ADDR_W-1:0]  sram_addr_r;
  logic [15:0]             dq_out_r;
  logic                    dq_oe_r;
  logic                    we_n_r;

  logic [31:0]             addr_off_s;
  logic [29:0]             word_full_s;
  logic [WI_W-1:0]         word_index_s;
  logic                    req_s;
  logic                    addr_bad_s;
  logic                    ready_s;
  logic                    timer_clear_s;
  logic                    phase_done_s;
  logic                    phase_pre_done_s;
  logic                    unused_bits_s;

  assign addr_off_s    = address - ADDR_BASE;
  assign word_full_s   = addr_off_s[31:2];
  assign word_index_s  = word_full_s[WI_W-1:0];
  assign req_s         = wr_en | rd_en;
  assign unused_bits_s = ^{addr_off_s[1:0], word_full_s[29:WI_W]};

`ifdef SRAM_ADDR_CHECK_EN
  logic addr_err_r;

  assign addr_bad_s = (address < ADDR_BASE) || ((word_full_s >> WI_W) != 30'd0);

  // Error flag is high only during the DONE cycle of a rejected request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_err_r <= 1'b0;
    end else begin
      addr_err_r <= (state_r == IDLE) && req_s && addr_bad_s;
    end
  end

  assign addr_err = addr_err_r;
`else
  assign addr_bad_s = 1'b0;
`endif

  // Ready: combinational in IDLE so a new request freezes the pipeline immediately.
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      IDLE:    ready_s = ~req_s;
      DONE:    ready_s = 1'b1;
      default: ready_s = 1'b0;
    endcase
  end

  // The phase timer runs only inside LOW/HIGH and restarts at each phase boundary.
  always_comb begin
    timer_clear_s = 1'b1;
    case (state_r)
      LOW, HIGH: timer_clear_s = phase_done_s;
      default:   timer_clear_s = 1'b1;
    endcase
  end

  sram_phase_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear_s),
    .done     (phase_done_s),
    .pre_done (phase_pre_done_s)
  );

  // Access sequencer: all SRAM-side outputs are registered so they change only at phase edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      op_wr_r     <= 1'b0;
      word_r      <= '0;
      wdata_r     <= 32'd0;
      read_data_r <= 32'd0;
      sram_addr_r <= '0;
      dq_out_r    <= 16'd0;
      dq_oe_r     <= 1'b0;
      we_n_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            op_wr_r <= wr_en;
            word_r  <= word_index_s;
            wdata_r <= write_data;
            if (addr_bad_s) begin
              state_r <= DONE;
              if (!wr_en) begin
                read_data_r <= 32'd0;
              end
            end else begin
              state_r     <= LOW;
              sram_addr_r <= {word_index_s, HALF_LO};
              dq_out_r    <= wr_en ? write_data[15:0] : 16'd0;
              dq_oe_r     <= wr_en;
              we_n_r      <= ~wr_en;
            end
          end
        end
        LOW: begin
          if (phase_done_s) begin
            state_r     <= HIGH;
            sram_addr_r <= {word_r, HALF_HI};
            dq_out_r    <= op_wr_r ? wdata_r[31:16] : 16'd0;
            we_n_r      <= ~op_wr_r;
            if (!op_wr_r) begin
              read_data_r[15:0] <= sram_dq_in;
            end
          end else begin
            // Strobe rises one cycle before the phase ends to give data hold time.
            we_n_r <= ~op_wr_r | phase_pre_done_s;
          end
        end
        HIGH: begin
          if (phase_done_s) begin
            state_r <= DONE;
            we_n_r  <= 1'b1;
            dq_oe_r <= 1'b0;
            if (!op_wr_r) begin
              read_data_r[31:16] <= sram_dq_in;
            end
          end else begin
            we_n_r <= ~op_wr_r | phase_pre_done_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign read_data   = read_data_r;
  assign ready       = ready_s;
  assign sram_addr   = sram_addr_r;
  assign sram_dq_out = dq_out_r;
  assign sram_dq_oe  = dq_oe_r;
  assign sram_we_n   = we_n_r;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: expected SRAM writes and load results are queued at issue
// and checked when the strobe / completion is observed on the falling clock edge.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  logic [15:0] mem [0:255];

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;

  always #5 clk = ~clk;

  assign sram_dq_in = mem[sram_addr[7:0]];

  mem_stage_sram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
`ifdef SRAM_ADDR_CHECK_EN
    .addr_err    (addr_err),
`endif
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  // Advance to the next falling edge, checking any write strobe against the scoreboard and storing it.
  task automatic step();
    wr_t e;
    @(negedge clk);
    if (!rst && sram_we_n === 1'b0) begin
      strobes++;
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected addr=%h dq=%h", sram_addr, sram_dq_out);
      end else begin
        e = wq.pop_front();
        if (sram_addr !== e.addr || sram_dq_out !== e.data || sram_dq_oe !== 1'b1) begin
          errors++;
          $display("FAIL strobe addr=%h dq=%h oe=%b expected addr=%h dq=%h oe=1",
                   sram_addr, sram_dq_out, sram_dq_oe, e.addr, e.data);
        end
      end
      mem[sram_addr[7:0]] = sram_dq_out;
    end
  endtask

  // Issue one access and run to its ready cycle; lat counts cycles with ready=0.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input bit from_done, output int lat);
    logic [31:0] off;
    logic [17:0] lo;
    wr_t         e;
    off = a - 32'd1024;
    lo  = {off[18:2], 1'b0};
    if (w) begin
      e.addr = lo;          e.data = d[15:0];  wq.push_back(e);
      e.addr = lo + 18'd1;  e.data = d[31:16]; wq.push_back(e);
    end else if (r) begin
      rq.push_back({mem[lo[7:0] + 8'd1], mem[lo[7:0]]});
    end
    wr_en = w; rd_en = r; address = a; write_data = d;
    if (from_done) step();
    #1;
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      lat++;
      step();
    end
    checks++;
    if (lat >= 40) begin
      errors++;
      $display("FAIL timeout ready never rose addr=%h", a);
    end
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL done_strobes we_n=%b oe=%b expected we_n=1 oe=0", sram_we_n, sram_dq_oe);
    end
    if (r && !w) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL load_scoreboard empty at completion");
      end else if (read_data !== rq[0]) begin
        errors++;
        $display("FAIL load_data got=%h expected=%h", read_data, rq.pop_front());
      end else begin
        void'(rq.pop_front());
      end
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready=%b we_n=%b oe=%b expected 1 1 0", ready, sram_we_n, sram_dq_oe);
    end
    checks++;
    if (read_data !== 32'd0 || sram_addr !== 18'd0 || sram_dq_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_data rd=%h addr=%h dq=%h expected 0 0 0", read_data, sram_addr, sram_dq_out);
    end
    rst = 1'b0;
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b expected 1", ready);
    end
  endtask

  task automatic test_store();
    int lat;
    int s0;
    s0 = strobes;
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, lat);
    checks++;
    if (lat != 5) begin
      errors++;
      $display("FAIL store_latency got=%0d expected=5", lat);
    end
    checks++;
    if (strobes - s0 != 2 || wq.size() != 0) begin
      errors++;
      $display("FAIL store_strobes got=%0d pending=%0d expected 2 0", strobes - s0, wq.size());
    end
    idle_inputs();
    step();
    checks++;
    if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD || ready !== 1'b1) begin
      errors++;
      $display("FAIL store_mem m0=%h m1=%h ready=%b expected BEEF DEAD 1", mem[0], mem[1], ready);
    end
  endtask

  task automatic test_load();
    int lat;
    mem[2] = 16'h5678;
    mem[3] = 16'h1234;
    access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, lat);
    checks++;
    if (lat != 5 || read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL load_basic lat=%0d rd=%h expected 5 12345678", lat, read_data);
    end
    idle_inputs();
    repeat (3) step();
    checks++;
    if (read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL load_hold rd=%h expected 12345678", read_data);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    int s0;
    mem[6] = 16'h9ABC;
    mem[7] = 16'h3C3C;
    s0 = strobes;
    access(1'b0, 1'b1, 32'd1036, 32'd0, 1'b0, lat1);
    checks++;
    if (strobes != s0 || read_data !== 32'h3C3C9ABC) begin
      errors++;
      $display("FAIL b2b_load strobes=%0d rd=%h expected 0 3C3C9ABC", strobes - s0, read_data);
    end
    access(1'b1, 1'b0, 32'd1040, 32'hA5A5C3C3, 1'b1, lat2);
    checks++;
    if (lat1 != 5 || lat2 != 5) begin
      errors++;
      $display("FAIL b2b_latency got=%0d,%0d expected 5,5", lat1, lat2);
    end
    checks++;
    if (strobes - s0 != 2 || mem[8] !== 16'hC3C3 || mem[9] !== 16'hA5A5) begin
      errors++;
      $display("FAIL b2b_store strobes=%0d m8=%h m9=%h expected 2 C3C3 A5A5", strobes - s0, mem[8], mem[9]);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    wr_t e;
    e.addr = 18'd10; e.data = 16'hF00D; wq.push_back(e);
    e.addr = 18'd11; e.data = 16'hCAFE; wq.push_back(e);
    wr_en = 1'b1; address = 32'd1044; write_data = 32'hCAFEF00D;
    repeat (3) step();
    #1;
    rst = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ctrl we_n=%b oe=%b ready=%b expected 1 0 1", sram_we_n, sram_dq_oe, ready);
    end
    checks++;
    if (read_data !== 32'd0 || sram_addr !== 18'd0) begin
      errors++;
      $display("FAIL midreset_data rd=%h addr=%h expected 0 0", read_data, sram_addr);
    end
    step();
    rst = 1'b0;
    wq.delete();
    rq.delete();
    repeat (3) step();
    checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_addr !== 18'd0) begin
      errors++;
      $display("FAIL midreset_idle ready=%b we_n=%b addr=%h expected 1 1 0", ready, sram_we_n, sram_addr);
    end
  endtask

  task automatic test_both_requests();
    int lat;
    access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, lat);
    idle_inputs();
    step();
    access(1'b1, 1'b1, 32'd1048, 32'h0BADF00D, 1'b0, lat);
    idle_inputs();
    step();
    checks++;
    if (mem[12] !== 16'hF00D || mem[13] !== 16'h0BAD || wq.size() != 0) begin
      errors++;
      $display("FAIL both_store m12=%h m13=%h pending=%0d expected F00D 0BAD 0", mem[12], mem[13], wq.size());
    end
    checks++;
    if (read_data !== 32'h12345678) begin
      errors++;
      $display("FAIL both_readdata rd=%h expected 12345678", read_data);
    end
  endtask

`ifdef SRAM_ADDR_CHECK_EN
  task automatic test_addr_err();
    int lat;
    int s0;
    logic [17:0] a0;
    s0 = strobes;
    a0 = sram_addr;
    rd_en = 1'b1; address = 32'd512;
    #1;
    lat = 0;
    while (ready !== 1'b1 && lat < 40) begin
      lat++;
      step();
    end
    checks++;
    if (lat != 1 || addr_err !== 1'b1 || read_data !== 32'd0) begin
      errors++;
      $display("FAIL addr_err_done lat=%0d err=%b rd=%h expected 1 1 0", lat, addr_err, read_data);
    end
    checks++;
    if (strobes != s0 || sram_addr !== a0) begin
      errors++;
      $display("FAIL addr_err_quiet strobes=%0d addr=%h expected 0 %h", strobes - s0, sram_addr, a0);
    end
    idle_inputs();
    step();
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL addr_err_pulse err=%b expected 0", addr_err);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid();
    test_both_requests();
`ifdef SRAM_ADDR_CHECK_EN
    test_addr_err();
`endif
    checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain writes=%0d loads=%0d expected 0 0", wq.size(), rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
